// File: rtl/stm32_audio_bridge.sv
// STM32 parallel-bus audio bridge. It synchronises the MCU strobe, enable and
// data, buffers the samples in a show-ahead FIFO, and feeds signed 32-bit samples to Audio_Controller.
module stm32_audio_bridge #(
  parameter int IN_WIDTH     = 12,
  parameter int OUT_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int PREFILL      = 8,
  parameter int READY_MARGIN = 4
)(
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [IN_WIDTH-1:0]           audio_in,
  input  logic                          audio_wr,
  input  logic                          audio_enable,
  output logic                          audio_ready,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [OUT_WIDTH-1:0]          left_channel_audio_out,
  output logic [OUT_WIDTH-1:0]          right_channel_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] L_FULL    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] L_PREFILL = LW'(PREFILL);
  localparam logic [LW-1:0] L_READY   = LW'(FIFO_DEPTH - READY_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_wr_s, r_en_s;
  logic                 r_wr_d;
  logic [IN_WIDTH-1:0]  r_in_s1, r_in_s2;
  logic [IN_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd, w_rd_nxt;
  logic [LW-1:0]        r_level, w_level_nxt;
  logic [OUT_WIDTH-1:0] r_head, w_head_nxt;
  logic [IN_WIDTH-1:0]  w_head_raw;
  logic                 r_ready, r_ovf, r_unr;
  logic                 w_en, w_push, w_full, w_empty, w_flush, w_active;
  logic                 w_pop, w_wr_ok, w_drop;

  // Offset binary to two's complement is an MSB flip, then left-justify.
  function automatic logic [OUT_WIDTH-1:0] conv(input logic [IN_WIDTH-1:0] x);
    return {~x[IN_WIDTH-1], x[IN_WIDTH-2:0], {(OUT_WIDTH-IN_WIDTH){1'b0}}};
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_s  <= '0;
      r_en_s  <= '0;
      r_wr_d  <= 1'b0;
      r_in_s1 <= '0;
      r_in_s2 <= '0;
    end else begin
      r_wr_s  <= {r_wr_s[0], audio_wr};
      r_en_s  <= {r_en_s[0], audio_enable};
      r_wr_d  <= r_wr_s[1];
      r_in_s1 <= audio_in;
      r_in_s2 <= r_in_s1;
    end
  end

  assign w_en     = r_en_s[1];
  assign w_push   = r_wr_s[1] & ~r_wr_d;
  assign w_full   = (r_level == L_FULL);
  assign w_empty  = (r_level == '0);
  assign w_flush  = ~w_en | (r_state == S_IDLE);
  assign w_active = ~w_flush;

  // FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (!w_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FILL;
        S_FILL:  if (r_level >= L_PREFILL) w_state_nxt = S_RUN;
        S_RUN:   if (audio_out_allowed && w_empty) w_state_nxt = S_FILL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_pop = (r_state == S_RUN) & audio_out_allowed & ~w_empty;
  end

  // A push into a full FIFO still fits if the same cycle pops.
  assign w_wr_ok = w_push & w_active & (~w_full | w_pop);
  assign w_drop  = w_push & w_active & w_full & ~w_pop;
  assign w_rd_nxt = r_rd + AW'(w_pop);

  always_comb begin
    w_level_nxt = r_level + LW'(w_wr_ok) - LW'(w_pop);
    if (w_flush) w_level_nxt = '0;
  end

  // Next head is the sample being written now when it lands on the new read slot.
  always_comb begin
    w_head_raw = r_mem[w_rd_nxt];
    if (w_wr_ok && (w_rd_nxt == r_wr)) w_head_raw = r_in_s2;
    w_head_nxt = conv(w_head_raw);
    if (w_level_nxt == '0) w_head_nxt = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr_ok) r_mem[r_wr] <= r_in_s2;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_head  <= '0;
      r_ready <= 1'b0;
      r_ovf   <= 1'b0;
      r_unr   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_head  <= w_head_nxt;
      r_ready <= (w_state_nxt != S_IDLE) & (w_level_nxt < L_READY);
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        r_wr <= r_wr + AW'(w_wr_ok);
        r_rd <= w_rd_nxt;
      end
      if (r_state == S_IDLE && w_en) begin
        r_ovf <= 1'b0;
        r_unr <= 1'b0;
      end else begin
        if (w_drop) r_ovf <= 1'b1;
        if (w_en && r_state == S_RUN && audio_out_allowed && w_empty) r_unr <= 1'b1;
      end
    end
  end

  assign write_audio_out         = w_pop;
  assign audio_ready             = r_ready;
  assign left_channel_audio_out  = r_head;
  assign right_channel_audio_out = r_head;
  assign fifo_level              = r_level;
  assign overflow                = r_ovf;
  assign underrun                = r_unr;
endmodule

// File: tb/tb_stm32_audio_bridge.sv
// Scoreboard bench for stm32_audio_bridge: accepted samples are queued with their
// expected codec word, and every write_audio_out cycle is checked against the queue head.
module tb_stm32_audio_bridge;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] audio_in = '0;
  logic        audio_wr = 1'b0;
  logic        audio_enable = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic        audio_ready, write_audio_out, overflow, underrun;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic [4:0]  fifo_level;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  logic [31:0] sb[$];

  stm32_audio_bridge dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .audio_in(audio_in), .audio_wr(audio_wr),
    .audio_enable(audio_enable), .audio_ready(audio_ready),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] exp_conv(input logic [11:0] v);
    int s;
    s = int'(v) - 2048;
    return s << 20;
  endfunction

  // Consumer side of the scoreboard
  always @(negedge CLOCK_50) begin
    if (write_audio_out === 1'b1) begin
      logic [31:0] e;
      n_wr++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL write_on_empty: got write with left=%h, expected no write", left_channel_audio_out);
      end else begin
        e = sb.pop_front();
        if (left_channel_audio_out !== e) begin
          n_bad++;
          $display("FAIL sample_data: got %h expected %h", left_channel_audio_out, e);
        end
      end
      n_cmp++;
      if (right_channel_audio_out !== left_channel_audio_out) begin
        n_bad++;
        $display("FAIL left_eq_right: right %h left %h", right_channel_audio_out, left_channel_audio_out);
      end
    end
  end

  task automatic clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [11:0] v, input bit keep);
    audio_in = v;
    clk(3);
    if (keep) sb.push_back(exp_conv(v));
    audio_wr = 1'b1;
    clk(4);
    audio_wr = 1'b0;
    clk(3);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      clk(1);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d samples still expected, expected 0", sb.size());
    end
  endtask

  task automatic restart;
    audio_enable = 1'b0;
    clk(4);
    audio_enable = 1'b1;
    clk(4);
    sb.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clk(3);
    n_cmp++;
    if ({audio_ready, write_audio_out, overflow, underrun} !== 4'b0 || fifo_level !== 5'd0 ||
        left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b wr=%b ovf=%b unr=%b lvl=%0d L=%h R=%h, expected all 0",
               audio_ready, write_audio_out, overflow, underrun, fifo_level,
               left_channel_audio_out, right_channel_audio_out);
    end
    reset = 1'b0;
    clk(3);
    n_cmp++;
    if (audio_ready !== 1'b0 || fifo_level !== 5'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset: rdy=%b lvl=%0d, expected 0/0", audio_ready, fifo_level);
    end
  endtask

  task automatic test_fill;
    audio_enable = 1'b1;
    clk(4);
    n_cmp++;
    if (audio_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_in_fill: got %b expected 1", audio_ready);
    end
    push(12'h800, 1);
    push(12'hFFF, 1);
    push(12'h000, 1);
    n_cmp++;
    if (fifo_level !== 5'd3) begin
      n_bad++;
      $display("FAIL fill_level: got %0d expected 3", fifo_level);
    end
    n_cmp++;
    if (left_channel_audio_out !== exp_conv(12'h800)) begin
      n_bad++;
      $display("FAIL show_ahead_head: got %h expected %h", left_channel_audio_out, exp_conv(12'h800));
    end
    audio_out_allowed = 1'b1;
    clk(5);
    audio_out_allowed = 1'b0;
    n_cmp++;
    if (fifo_level !== 5'd3 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_no_pop: lvl=%0d unr=%b expected 3/0", fifo_level, underrun);
    end
  endtask

  task automatic test_drain_underrun;
    int w0;
    push(12'h123, 1);
    push(12'hABC, 1);
    push(12'h7FF, 1);
    push(12'h801, 1);
    push(12'h400, 1);
    clk(2);
    w0 = n_wr;
    audio_out_allowed = 1'b1;
    wait_drain(100);
    clk(3);
    n_cmp++;
    if (n_wr - w0 != 8) begin
      n_bad++;
      $display("FAIL write_count: got %0d expected 8", n_wr - w0);
    end
    n_cmp++;
    if (fifo_level !== 5'd0 || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun: lvl=%0d unr=%b expected 0/1", fifo_level, underrun);
    end
    audio_out_allowed = 1'b0;
  endtask

  task automatic test_overflow;
    int w0;
    logic [11:0] v;
    int lvl;
    restart();
    n_cmp++;
    if (underrun !== 1'b0 || overflow !== 1'b0 || fifo_level !== 5'd0) begin
      n_bad++;
      $display("FAIL restart_clear: unr=%b ovf=%b lvl=%0d expected 0/0/0", underrun, overflow, fifo_level);
    end
    for (int i = 0; i < 20; i++) begin
      v = 12'(i * 209 + 53);
      push(v, i < 16);
      lvl = (i + 1 > 16) ? 16 : i + 1;
      n_cmp++;
      if (fifo_level !== 5'(lvl) || audio_ready !== (lvl < 12)) begin
        n_bad++;
        $display("FAIL ovf_level_ready[%0d]: lvl=%0d rdy=%b expected %0d/%b",
                 i, fifo_level, audio_ready, lvl, (lvl < 12));
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_flag: got %b expected 1", overflow);
    end
    w0 = n_wr;
    audio_out_allowed = 1'b1;
    wait_drain(100);
    clk(2);
    audio_out_allowed = 1'b0;
    n_cmp++;
    if (n_wr - w0 != 16) begin
      n_bad++;
      $display("FAIL ovf_retained: got %0d writes expected 16", n_wr - w0);
    end
  endtask

  task automatic test_back_to_back;
    restart();
    for (int i = 0; i < 16; i++) push(12'(i * 77 + 900), 1);
    n_cmp++;
    if (fifo_level !== 5'd16) begin
      n_bad++;
      $display("FAIL b2b_full: got %0d expected 16", fifo_level);
    end
    audio_in = 12'h5A5;
    clk(3);
    audio_wr = 1'b1;
    clk(2);
    sb.push_back(exp_conv(12'h5A5));
    audio_out_allowed = 1'b1;
    clk(1);
    audio_out_allowed = 1'b0;
    clk(2);
    audio_wr = 1'b0;
    clk(3);
    n_cmp++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_push_pop: lvl=%0d ovf=%b expected 16/0", fifo_level, overflow);
    end
    audio_out_allowed = 1'b1;
    wait_drain(100);
    clk(2);
    audio_out_allowed = 1'b0;
  endtask

  task automatic test_enable_reset;
    int w0;
    for (int i = 0; i < 3; i++) push(12'(i * 5 + 300), 1);
    n_cmp++;
    if (fifo_level !== 5'd3 || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_drop: lvl=%0d unr=%b expected 3/1", fifo_level, underrun);
    end
    audio_enable = 1'b0;
    clk(2);
    n_cmp++;
    if (fifo_level !== 5'd3) begin
      n_bad++;
      $display("FAIL drop_latency_early: lvl=%0d expected 3", fifo_level);
    end
    clk(1);
    n_cmp++;
    if (fifo_level !== 5'd0 || audio_ready !== 1'b0 || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_flush: lvl=%0d rdy=%b unr=%b expected 0/0/1", fifo_level, audio_ready, underrun);
    end
    sb.delete();
    audio_enable = 1'b1;
    clk(4);
    n_cmp++;
    if (underrun !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reenable_clear: unr=%b ovf=%b expected 0/0", underrun, overflow);
    end
    for (int i = 0; i < 7; i++) push(12'(i * 333 + 17), 1);
    w0 = n_wr;
    audio_out_allowed = 1'b1;
    clk(5);
    n_cmp++;
    if (fifo_level !== 5'd7 || n_wr != w0) begin
      n_bad++;
      $display("FAIL prefill_hold: lvl=%0d writes=%0d expected 7/0", fifo_level, n_wr - w0);
    end
    push(12'hC00, 1);
    wait_drain(100);
    clk(2);
    audio_out_allowed = 1'b0;
    n_cmp++;
    if (n_wr - w0 != 8) begin
      n_bad++;
      $display("FAIL prefill_drain: got %0d writes expected 8", n_wr - w0);
    end
    // reset mid-stream with a strobe in flight
    for (int i = 0; i < 3; i++) push(12'(i + 40), 1);
    audio_in = 12'h321;
    clk(3);
    audio_wr = 1'b1;
    clk(1);
    reset = 1'b1;
    clk(1);
    reset = 1'b0;
    sb.delete();
    n_cmp++;
    if (fifo_level !== 5'd0 || underrun !== 1'b0 || overflow !== 1'b0 || audio_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_reset: lvl=%0d unr=%b ovf=%b rdy=%b expected 0/0/0/0",
               fifo_level, underrun, overflow, audio_ready);
    end
    clk(4);
    audio_wr = 1'b0;
    clk(3);
    n_cmp++;
    if (fifo_level !== 5'd0) begin
      n_bad++;
      $display("FAIL strobe_lost: lvl=%0d expected 0", fifo_level);
    end
    w0 = n_wr;
    audio_out_allowed = 1'b1;
    for (int i = 0; i < 8; i++) push(12'(i * 500 + 1), 1);
    wait_drain(100);
    audio_out_allowed = 1'b0;
    n_cmp++;
    if (n_wr - w0 != 8) begin
      n_bad++;
      $display("FAIL post_reset_stream: got %0d writes expected 8", n_wr - w0);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_underrun();
    test_overflow();
    test_back_to_back();
    test_enable_reset();
    clk(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
